controla_fluxo_multi: RTL and testbench
=======================================

# controla_fluxo_multi

Parametrised multi-lane access-flow controller for the gate system. It is the successor of the single-lane flow controller: it handles LANES entry lanes and one shared occupancy counter against a configurable capacity, with a per-lane password-retry lockout and an optional passage timeout. It runs on the divided system clock, downstream of the frequency divider. Sensor inputs arrive already synchronised to CLK.

## Interface
- LANES, 2, number of entry lanes (1..8)
- CAP, 15, maximum occupancy (1..255)
- MAX_TRIES, 3, wrong-password attempts before lane lockout (1..7)
- TIMEOUT, 700, cycles allowed in OPEN before the grant is revoked (700 = 1 s at 700 Hz)
- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- SE  in  LANES  entry sensor per lane, vehicle present at gate
- SI  in  LANES  inner sensor per lane, vehicle has passed the gate
- SX  in  LANES  exit sensor per lane; each rising edge is one vehicle leaving
- Senha_ok  in  LANES  one-cycle pulse, correct password entered
- Senha_err  in  LANES  one-cycle pulse, wrong password entered
- Unlock  in  LANES  operator release of a blocked lane
- Liberado  out  LANES  gate open
- Pare  out  LANES  stop light
- Bloqueado  out  LANES  lane locked out
- Full  out  1  occupancy == CAP
- Ocupacao  out  $clog2(CAP+1)  current occupancy
- state  out  2*LANES  packed lane states, lane i at bits [2i+1:2i]

## Operation
- Per-lane Moore FSM. States and encodings: IDLE=0, WAIT_PW=1, OPEN=2, BLOCK=3.
- Edge detection: rise(x) = x & ~x_q, where x_q is a one-cycle-delayed register of x. It applies to SE, SI and SX. Senha_ok, Senha_err and Unlock are level-sampled.
- IDLE:
  - rise(SE[i]) goes to WAIT_PW. The lane enters WAIT_PW even when Full.
- WAIT_PW, conditions in priority order:
  - SE[i] low: go to IDLE. The try count is kept.
  - Senha_ok[i] with a grant: go to OPEN.
  - Senha_ok[i] without a grant: stay in WAIT_PW. The request is dropped and must be re-pulsed.
  - Senha_err[i]: tries+1. If the new count equals MAX_TRIES, go to BLOCK.
  - Senha_ok and Senha_err in the same cycle: treated as Senha_err.
- Grant arbitration: free = CAP − Ocupacao at the current cycle.
  - Requesting lanes are granted in ascending index order, up to free grants.
  - Exits in the same cycle do not add to free.
- OPEN:
  - The slot is already counted in Ocupacao on grant.
  - rise(SI[i]) goes to IDLE and clears tries.
- BLOCK: Unlock[i] goes to IDLE and clears tries. SE, SI and password inputs are ignored.
- Occupancy update: Ocupacao_next = Ocupacao + grants − exits − refunds.
  - Exits are counted only while Ocupacao > 0, applied per lane in ascending order.
  - The result never exceeds CAP and never wraps below 0.
- Outputs, decoded from state:
  - Liberado = OPEN.
  - Bloqueado = BLOCK.
  - Pare = BLOCK | WAIT_PW | (IDLE & SE[i]).
- Full = (Ocupacao == CAP).

## Timing
- Reset values: all lanes IDLE, tries 0, Ocupacao 0, x_q 0. Liberado=0, Pare=0, Bloqueado=0, Full=0, state=0.
- Latency: an input sampled at edge k changes state, outputs and Ocupacao immediately after edge k (one-cycle response).
- A rise requires input low at edge k−1 and high at edge k.
- Reset asserted mid-OPEN: the lane returns to IDLE, Ocupacao returns to 0, and no refund is applied.
- Simultaneous SX and grant at Ocupacao == CAP: the exit is applied and the grant is denied. Ocupacao becomes CAP−1.

## Configuration
- CF_TIMEOUT_EN defined:
  - A per-lane cycle counter starts on entry to OPEN.
  - After TIMEOUT cycles in OPEN without rise(SI), the lane goes to IDLE and the slot is refunded (Ocupacao −1).
  - rise(SI) in the same cycle as expiry wins; no refund.
- CF_TIMEOUT_EN undefined: no counter is built and OPEN is held indefinitely. TIMEOUT is ignored.

## Structure
- Package controla_fluxo_pkg holds:
  - the state encodings IDLE, WAIT_PW, OPEN and BLOCK;
  - the width helper for Ocupacao.
- Sub-module controla_fluxo_lane contains the per-lane FSM, the try counter and the optional timeout counter.
  - It outputs its grant request and its refund pulse.
- The top-level module holds the arbiter, the occupancy counter and the edge registers. It instantiates the lane module LANES times with a generate loop.

## Test plan
- Single lane, CAP=15: SE rise, Senha_ok, then SI rise. Expect WAIT_PW, then Liberado=1 and Ocupacao=1, then IDLE with Pare=0.
- Three Senha_err pulses with MAX_TRIES=3: Bloqueado=1 and state=3. Senha_ok is then ignored. Unlock returns the lane to IDLE with tries=0.
- Ocupacao=14, CAP=15, Senha_ok on lanes 0 and 1 in the same cycle: lane 0 goes to OPEN, lane 1 stays in WAIT_PW, Full=1 and Ocupacao=15.
- Ocupacao=15: SX rise and Senha_ok in the same cycle. Expect Ocupacao=14 and no grant. A re-pulsed Senha_ok is then granted and Ocupacao returns to 15.
- CF_TIMEOUT_EN defined, TIMEOUT=700: grant with no SI. After 700 cycles Liberado falls and Ocupacao is decremented by 1.
- Ocupacao=0 with an SX rise: Ocupacao stays 0. reset asserted mid-OPEN: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/controla_fluxo_pkg.sv
// Shared definitions for the multi-lane flow controller.
// Holds the lane state encodings and the occupancy width helper.
package controla_fluxo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_PW = 2'd1,
    OPEN    = 2'd2,
    BLOCK   = 2'd3
  } lane_state_t;

  function automatic int occ_width(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/controla_fluxo_lane.sv
// One entry lane: access FSM, wrong-password counter and, when CF_TIMEOUT_EN
// is defined, a down-counter that revokes an unused grant after TIMEOUT cycles.
//
// state   | meaning
// IDLE    | no vehicle being served
// WAIT_PW | vehicle at gate, waiting for password / free slot
// OPEN    | gate open, slot already counted in occupancy
// BLOCK   | too many wrong passwords, waits for operator unlock
module controla_fluxo_lane
  import controla_fluxo_pkg::*;
#(
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        se,
  input  logic        se_rise,
  input  logic        si_rise,
  input  logic        senha_ok,
  input  logic        senha_err,
  input  logic        unlock,
  input  logic        grant,
  output logic        req,
  output logic        refund,
  output lane_state_t st,
  output logic        liberado,
  output logic        pare,
  output logic        bloqueado
);

  lane_state_t st_n;
  logic [2:0]  tries;
  logic [2:0]  tries_n;
  logic        expired;

  // A simultaneous error pulse overrides a correct password, so no request then.
  assign req    = (st == WAIT_PW) && se && senha_ok && !senha_err;
  assign refund = expired && !si_rise;

`ifdef CF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;

  assign expired = (st == OPEN) && (tmr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if (st == WAIT_PW && st_n == OPEN) begin
      tmr <= TW'(TIMEOUT - 1);
    end else if (st == OPEN && tmr != '0) begin
      tmr <= tmr - 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    st_n    = st;
    tries_n = tries;
    case (st)
      IDLE: begin
        if (se_rise) st_n = WAIT_PW;
      end
      WAIT_PW: begin
        if (!se) begin
          st_n = IDLE;
        end else if (senha_err) begin
          tries_n = tries + 3'd1;
          if (tries_n == 3'(MAX_TRIES)) st_n = BLOCK;
        end else if (senha_ok && grant) begin
          st_n = OPEN;
        end
      end
      OPEN: begin
        if (si_rise) begin
          st_n    = IDLE;
          tries_n = '0;
        end else if (expired) begin
          st_n = IDLE;
        end
      end
      BLOCK: begin
        if (unlock) begin
          st_n    = IDLE;
          tries_n = '0;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      tries     <= '0;
      liberado  <= 1'b0;
      pare      <= 1'b0;
      bloqueado <= 1'b0;
    end else begin
      st        <= st_n;
      tries     <= tries_n;
      liberado  <= (st_n == OPEN);
      bloqueado <= (st_n == BLOCK);
      pare      <= (st_n == BLOCK) || (st_n == WAIT_PW) || (st_n == IDLE && se);
    end
  end

endmodule

// File: rtl/controla_fluxo_multi.sv
// Multi-lane access-flow controller: edge registers, grant arbiter and shared
// occupancy counter around LANES lane FSMs. Optional timeout: CF_TIMEOUT_EN.
module controla_fluxo_multi
  import controla_fluxo_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int CAP       = 15,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 700
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [LANES-1:0]          SE,
  input  logic [LANES-1:0]          SI,
  input  logic [LANES-1:0]          SX,
  input  logic [LANES-1:0]          Senha_ok,
  input  logic [LANES-1:0]          Senha_err,
  input  logic [LANES-1:0]          Unlock,
  output logic [LANES-1:0]          Liberado,
  output logic [LANES-1:0]          Pare,
  output logic [LANES-1:0]          Bloqueado,
  output logic                      Full,
  output logic [occ_width(CAP)-1:0] Ocupacao,
  output logic [2*LANES-1:0]        state
);

  localparam int OW = occ_width(CAP);

  logic [LANES-1:0] se_q, si_q, sx_q;
  logic [LANES-1:0] se_rise, si_rise, sx_rise;
  logic [LANES-1:0] req, grant, refund;
  lane_state_t      lane_st [LANES];
  logic [OW-1:0]    occ_next;
  int               free_cnt;
  int               gcnt;
  int               tmp;

  assign se_rise = SE & ~se_q;
  assign si_rise = SI & ~si_q;
  assign sx_rise = SX & ~sx_q;

  // Grants are limited by the room at the start of the cycle; exits landing
  // in the same cycle do not free a slot until the next one.
  always_comb begin
    free_cnt = CAP - int'(Ocupacao);
    gcnt     = 0;
    grant    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (req[i] && gcnt < free_cnt) begin
        grant[i] = 1'b1;
        gcnt     = gcnt + 1;
      end
    end
  end

  always_comb begin
    tmp = int'(Ocupacao);
    for (int i = 0; i < LANES; i++) begin
      if (sx_rise[i] && tmp > 0) tmp = tmp - 1;
    end
    tmp = tmp + gcnt;
    for (int i = 0; i < LANES; i++) begin
      if (refund[i] && tmp > 0) tmp = tmp - 1;
    end
    occ_next = tmp[OW-1:0];
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      se_q     <= '0;
      si_q     <= '0;
      sx_q     <= '0;
      Ocupacao <= '0;
      Full     <= 1'b0;
    end else begin
      se_q     <= SE;
      si_q     <= SI;
      sx_q     <= SX;
      Ocupacao <= occ_next;
      Full     <= (int'(occ_next) == CAP);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    controla_fluxo_lane #(
      .MAX_TRIES (MAX_TRIES),
      .TIMEOUT   (TIMEOUT)
    ) u_lane (
      .clk       (CLK),
      .rst       (reset),
      .se        (SE[i]),
      .se_rise   (se_rise[i]),
      .si_rise   (si_rise[i]),
      .senha_ok  (Senha_ok[i]),
      .senha_err (Senha_err[i]),
      .unlock    (Unlock[i]),
      .grant     (grant[i]),
      .req       (req[i]),
      .refund    (refund[i]),
      .st        (lane_st[i]),
      .liberado  (Liberado[i]),
      .pare      (Pare[i]),
      .bloqueado (Bloqueado[i])
    );
    assign state[2*i +: 2] = lane_st[i];
  end

endmodule

// File: tb/tb_controla_fluxo_multi.sv
// Directed bench for controla_fluxo_multi with LANES=2, CAP=15, MAX_TRIES=3.
// Build with CF_TIMEOUT_EN defined to exercise the grant timeout.
module tb_controla_fluxo_multi;

  localparam int LANES   = 2;
  localparam int CAP     = 15;
  localparam int TRIES   = 3;
  localparam int TIMEOUT = 700;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] se, si, sx, ok, err, unl;
  logic [1:0] liberado, pare, bloqueado;
  logic       full;
  logic [3:0] ocupacao;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  se, si, sx, ok, err, unl;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  controla_fluxo_multi #(
    .LANES     (LANES),
    .CAP       (CAP),
    .MAX_TRIES (TRIES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CLK       (clk),
    .reset     (reset),
    .SE        (se),
    .SI        (si),
    .SX        (sx),
    .Senha_ok  (ok),
    .Senha_err (err),
    .Unlock    (unl),
    .Liberado  (liberado),
    .Pare      (pare),
    .Bloqueado (bloqueado),
    .Full      (full),
    .Ocupacao  (ocupacao),
    .state     (state)
  );

  // Expected outputs packed as {lib, pare, blq, full, occ, state}
  function automatic logic [14:0] eo(input logic [1:0] l, input logic [1:0] p,
                                     input logic [1:0] b, input logic f,
                                     input logic [3:0] o, input logic [3:0] s);
    return {l, p, b, f, o, s};
  endfunction

  function automatic vec_t mk(input logic [1:0] se_v, input logic [1:0] si_v,
                              input logic [1:0] sx_v, input logic [1:0] ok_v,
                              input logic [1:0] err_v, input logic [1:0] unl_v,
                              input logic [14:0] e);
    vec_t v;
    v.se = se_v; v.si = si_v; v.sx = sx_v;
    v.ok = ok_v; v.err = err_v; v.unl = unl_v;
    v.exp = e;
    return v;
  endfunction

  task automatic step(input logic [1:0] se_v, input logic [1:0] si_v,
                      input logic [1:0] sx_v, input logic [1:0] ok_v,
                      input logic [1:0] err_v, input logic [1:0] unl_v);
    @(negedge clk);
    se = se_v; si = si_v; sx = sx_v; ok = ok_v; err = err_v; unl = unl_v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [14:0] e);
    logic [14:0] got;
    got = {liberado, pare, bloqueado, full, ocupacao, state};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got lib=%b pare=%b blq=%b full=%b occ=%0d st=%b required lib=%b pare=%b blq=%b full=%b occ=%0d st=%b",
               nm, got[14:13], got[12:11], got[10:9], got[8], got[7:4], got[3:0],
               e[14:13], e[12:11], e[10:9], e[8], e[7:4], e[3:0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // se si sx ok err unl | lib pare blq full occ state
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000)));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b01, 2'b00, 0, 0, 4'b0001)));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, eo(2'b01, 2'b00, 2'b00, 0, 1, 4'b0010)));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b01, 2'b00, 0, 1, 4'b0000)));
    tbl.push_back(mk(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b00, 2'b00, 0, 1, 4'b0000)));
    tbl.push_back(mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, eo(2'b00, 2'b10, 2'b10, 0, 0, 4'b1100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, eo(2'b00, 2'b10, 2'b10, 0, 0, 4'b1100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0000)));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, eo(2'b00, 2'b10, 2'b10, 0, 0, 4'b1100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0000)));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, eo(2'b00, 2'b10, 2'b00, 0, 0, 4'b0100)));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, eo(2'b00, 2'b10, 2'b10, 0, 0, 4'b1100)));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000)));

    se = '0; si = '0; sx = '0; ok = '0; err = '0; unl = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset", eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].se, tbl[i].si, tbl[i].sx, tbl[i].ok, tbl[i].err, tbl[i].unl);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Fill to 14 vehicles through lane 0
    for (int k = 1; k <= 14; k++) begin
      step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      step(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      step(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      check($sformatf("fill%0d", k), eo(2'b00, 2'b00, 2'b00, 0, 4'(k), 4'b0000));
    end

    // Two lanes request the last slot together: lower index wins
    step(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    check("both_wait", eo(2'b00, 2'b11, 2'b00, 0, 14, 4'b0101));
    step(2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    check("last_slot", eo(2'b01, 2'b10, 2'b00, 1, 15, 4'b0110));
    step(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    check("lane0_pass", eo(2'b00, 2'b11, 2'b00, 1, 15, 4'b0100));
    // Exit and request at full: exit applied, grant denied
    step(2'b11, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00);
    check("exit_vs_grant", eo(2'b00, 2'b11, 2'b00, 0, 14, 4'b0100));
    step(2'b11, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00);
    check("repulse_grant", eo(2'b10, 2'b01, 2'b00, 1, 15, 4'b1000));
    step(2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    check("lane1_pass", eo(2'b00, 2'b11, 2'b00, 1, 15, 4'b0000));
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Drain with double exits; the last pair clamps at zero
    for (int k = 1; k <= 8; k++) begin
      step(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
      check($sformatf("drain%0d", k),
            eo(2'b00, 2'b00, 2'b00, 0, (15 - 2 * k) < 0 ? 4'd0 : 4'(15 - 2 * k), 4'b0000));
      step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    check("exit_at_zero", eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000));
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Grant with no passage
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    check("hold_grant", eo(2'b01, 2'b00, 2'b00, 0, 1, 4'b0010));
`ifdef CF_TIMEOUT_EN
    repeat (TIMEOUT - 1) step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    check("before_timeout", eo(2'b01, 2'b00, 2'b00, 0, 1, 4'b0010));
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    check("timeout_refund", eo(2'b00, 2'b01, 2'b00, 0, 0, 4'b0000));
`else
    repeat (TIMEOUT + 100) step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    check("open_held", eo(2'b01, 2'b00, 2'b00, 0, 1, 4'b0010));
`endif

    // Asynchronous reset while a lane is OPEN
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    check("open_before_reset", eo(2'b01, 2'b00, 2'b00, 0, 1, 4'b0010));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000));
    se = '0; ok = '0;
    @(negedge clk);
    reset = 1'b0;
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    check("after_reset", eo(2'b00, 2'b00, 2'b00, 0, 0, 4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
